// File: rtl/cmd_pkg.sv
// cmd_pkg: frame constants, opcode classes and parser state encoding for cmd_frame_parser
package cmd_pkg;
  localparam logic [7:0] HDR0 = 8'hEB;
  localparam logic [7:0] HDR1 = 8'h90;
  localparam logic [7:0] TAIL0 = 8'h09;
  localparam logic [7:0] TAIL1 = 8'hD7;
  localparam logic [7:0] DEF_DEST = 8'hAB;
  localparam logic [3:0] OP_SEL = 4'h0;
  localparam logic [3:0] OP_RST = 4'h1;
  localparam logic [3:0] OP_PON = 4'h2;
  localparam logic [3:0] OP_POFF = 4'h3;
  localparam logic [7:0] OP_ALL = 8'hF0;
  typedef enum logic [1:0] {HUNT0, HUNT1, BODY, EXEC} state_t;
endpackage

// File: rtl/cmd_rst_pulse.sv
// cmd_rst_pulse: retriggerable pulse, high for exactly RST_CYCLES cycles after the last trigger
module cmd_rst_pulse #(
  parameter int unsigned RST_CYCLES = 32'd50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic trig,
  output logic pulse
);
  logic [31:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= trig ? RST_CYCLES : cnt - {31'd0, cnt != '0};
  assign pulse = cnt != '0;
endmodule

// File: rtl/cmd_frame_parser.sv
// cmd_frame_parser: streaming 8-byte command frame parser driving host select, CPU resets and power enables.
// Define CMD_ECHO_EN to echo every popped RX byte to the TX FIFO.
module cmd_frame_parser
  import cmd_pkg::*;
#(
  parameter int NCH = 2,
  parameter int CNT_W = 5,
  parameter logic [7:0] DEST_ID = DEF_DEST,
  parameter int unsigned RST_CYCLES = 32'd50_000_000,
  parameter int unsigned IDLE_CYCLES = 640,
  localparam int SEL_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rdr,
  input  logic [CNT_W-1:0] rf_counter,
  output logic             rf_pop,
  output logic [7:0]       tdr,
  output logic             tf_push,
  input  logic [SEL_W-1:0] active_ch,
  output logic [SEL_W-1:0] com_sel,
  output logic             force_swi,
  output logic [NCH-1:0]   rst_out,
  output logic [NCH-1:0]   power_on,
  output logic             frame_ok,
  output logic             error
);
  state_t state, nxt;
  logic [2:0] idx;
  logic [31:0] idle_cnt;
  logic pop_q, timeout;
  logic [7:0] fr [2:7];
  logic [3:0] k;
  logic [NCH-1:0] mask, trig;
  logic valid, kin, is_act, sel_cmd, rst_cmd, pon_cmd, poff_cmd, all_cmd, ok_d, err_d, bad_hdr;
  assign timeout = (state == HUNT1 || state == BODY) && idle_cnt == IDLE_CYCLES;
  // pop_q resets high so no pop can leave while rst_n is held
  assign rf_pop = state != EXEC && rf_counter != '0 && !pop_q && !timeout;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= HUNT0;
      idx <= '0;
      idle_cnt <= '0;
      pop_q <= 1'b1;
    end else begin
      state <= nxt;
      pop_q <= rf_pop;
      idle_cnt <= ((state == HUNT1 || state == BODY) && !rf_pop && !timeout) ? idle_cnt + 32'd1 : '0;
      idx <= (state == HUNT1 && nxt == BODY) ? 3'd2 : (state == BODY && rf_pop) ? idx + 3'd1 : idx;
    end
  always_ff @(posedge clk)
    if (state == BODY && rf_pop) fr[idx] <= rdr;
  always_comb begin
    nxt = state;
    case (state)
      HUNT0: nxt = (rf_pop && rdr == HDR0) ? HUNT1 : HUNT0;
      HUNT1: nxt = timeout ? HUNT0 : !rf_pop ? HUNT1 : rdr == HDR1 ? BODY : rdr == HDR0 ? HUNT1 : HUNT0;
      BODY: nxt = timeout ? HUNT0 : (rf_pop && idx == 3'd7) ? EXEC : BODY;
      default: nxt = HUNT0;
    endcase
  end
  always_comb begin
    k = fr[4][3:0];
    mask = NCH'(1) << k;
    valid = fr[6] == TAIL0 && fr[7] == TAIL1 && fr[3] == DEST_ID && 8'(fr[2] + fr[3] + fr[4] + fr[5]) == 8'h00;
    kin = 32'(k) < NCH;
    is_act = k == 4'(active_ch);
    sel_cmd = state == EXEC && valid && kin && fr[4][7:4] == OP_SEL;
    rst_cmd = state == EXEC && valid && kin && fr[4][7:4] == OP_RST && !is_act;
    pon_cmd = state == EXEC && valid && kin && fr[4][7:4] == OP_PON;
    poff_cmd = state == EXEC && valid && kin && fr[4][7:4] == OP_POFF && !is_act;
    all_cmd = state == EXEC && valid && fr[4] == OP_ALL;
    ok_d = sel_cmd | rst_cmd | pon_cmd | poff_cmd | all_cmd;
    bad_hdr = state == HUNT1 && rf_pop && rdr != HDR1 && rdr != HDR0;
    err_d = (state == EXEC && !ok_d) || bad_hdr || timeout;
    trig = all_cmd ? '1 : rst_cmd ? mask : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      com_sel <= '0;
      force_swi <= 1'b0;
      power_on <= '1;
      frame_ok <= 1'b0;
      error <= 1'b0;
    end else begin
      com_sel <= sel_cmd ? k[SEL_W-1:0] : all_cmd ? '0 : com_sel;
      force_swi <= sel_cmd | all_cmd;
      power_on <= pon_cmd ? power_on | mask : poff_cmd ? power_on & ~mask : power_on;
      frame_ok <= ok_d;
      error <= err_d;
    end
  for (genvar i = 0; i < NCH; i++) begin : g_rst
    cmd_rst_pulse #(.RST_CYCLES(RST_CYCLES)) u_rst (.clk(clk), .rst_n(rst_n), .trig(trig[i]), .pulse(rst_out[i]));
  end
`ifdef CMD_ECHO_EN
  assign tf_push = rf_pop;
  assign tdr = rf_pop ? rdr : 8'h00;
`else
  assign tf_push = 1'b0;
  assign tdr = 8'h00;
`endif
endmodule

// File: tb/tb_cmd_frame_parser.sv
// tb_cmd_frame_parser: randomized frame stream against a frame-level reference model with an event scoreboard
module tb_cmd_frame_parser;
  localparam int NCH = 2;
  localparam int CNT_W = 5;
  localparam int RC = 16;
  localparam int IC = 40;
  localparam logic [7:0] DEST = 8'hAB;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rdr = 8'h00;
  logic [CNT_W-1:0] rf_counter = '0;
  logic rf_pop, tf_push, force_swi, frame_ok, error;
  logic [7:0] tdr;
  logic [0:0] active_ch = 1'b0, com_sel;
  logic [NCH-1:0] rst_out, power_on;
  cmd_frame_parser #(.NCH(NCH), .CNT_W(CNT_W), .DEST_ID(DEST), .RST_CYCLES(RC), .IDLE_CYCLES(IC)) dut (
    .clk(clk), .rst_n(rst_n), .rdr(rdr), .rf_counter(rf_counter), .rf_pop(rf_pop), .tdr(tdr),
    .tf_push(tf_push), .active_ch(active_ch), .com_sel(com_sel), .force_swi(force_swi),
    .rst_out(rst_out), .power_on(power_on), .frame_ok(frame_ok), .error(error));
  always #5 clk = ~clk;
  typedef struct packed {logic ok; logic err; logic fsw; logic [0:0] sel; logic [NCH-1:0] pon; logic [NCH-1:0] trig;} ev_t;
  ev_t exp_q[$];
  logic [7:0] fifo[$];
  int total = 0, bad = 0, pops_seen = 0, pops_done = 0;
  logic last_pop = 1'b0;
  int rem[NCH];
  logic [0:0] m_sel = 1'b0;
  logic [NCH-1:0] m_pon = '1;
  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
    end
  endfunction
  // UART FIFO side: a pop is taken at the edge and the head advances at the following negedge
  always @(posedge clk) begin
    if (rst_n && rf_pop) begin
      chk("pop_nonempty", fifo.size() != 0, 1);
      chk("pop_spacing", last_pop, 0);
`ifdef CMD_ECHO_EN
      chk("echo", {tf_push, tdr}, {1'b1, rdr});
`else
      chk("echo_off", {tf_push, tdr}, 0);
`endif
      pops_seen <= pops_seen + 1;
    end
    last_pop <= rf_pop;
  end
  always @(negedge clk) begin : mon
    ev_t e;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) rem[c] = 0;
    end else begin
      if (frame_ok || error) begin
        if (exp_q.size() == 0) chk("unexpected_event", {frame_ok, error}, 0);
        else begin
          e = exp_q.pop_front();
          chk("event", {frame_ok, error, force_swi, com_sel, power_on}, {e.ok, e.err, e.fsw, e.sel, e.pon});
          for (int c = 0; c < NCH; c++) if (e.trig[c]) rem[c] = RC;
        end
      end else chk("quiet_fsw", force_swi, 0);
      for (int c = 0; c < NCH; c++) begin
        chk("rst_out", rst_out[c], rem[c] > 0);
        if (rem[c] > 0) rem[c]--;
      end
    end
  end
  task automatic tick();
    @(negedge clk);
    while (pops_done < pops_seen) begin
      fifo.delete(0);
      pops_done++;
    end
    rdr = fifo.size() != 0 ? fifo[0] : 8'h00;
    rf_counter = CNT_W'(fifo.size());
  endtask
  // frame-level rules: validity, then opcode class and channel checks
  function automatic ev_t model(logic [7:0] s, logic [7:0] d, logic [7:0] o, logic [7:0] c, logic [7:0] t6, logic [7:0] t7);
    ev_t e = '0;
    int k = int'(o[3:0]);
    e.sel = m_sel;
    e.pon = m_pon;
    if (t6 != 8'h09 || t7 != 8'hD7 || d != DEST || 8'(s + d + o + c) != 8'h00) e.err = 1'b1;
    else if (o == 8'hF0) begin e.ok = 1'b1; e.fsw = 1'b1; e.sel = 1'b0; e.trig = '1; end
    else if (k >= NCH || o[7:4] > 4'd3) e.err = 1'b1;
    else if (o[7:4] == 4'd0) begin e.ok = 1'b1; e.fsw = 1'b1; e.sel = o[0]; end
    else if (o[7:4] == 4'd1) begin
      if (k == int'(active_ch)) e.err = 1'b1; else begin e.ok = 1'b1; e.trig[k] = 1'b1; end
    end else if (o[7:4] == 4'd2) begin e.ok = 1'b1; e.pon[k] = 1'b1; end
    else begin
      if (k == int'(active_ch)) e.err = 1'b1; else begin e.ok = 1'b1; e.pon[k] = 1'b0; end
    end
    m_sel = e.sel;
    m_pon = e.pon;
    return e;
  endfunction
  function automatic logic [7:0] junk();
    logic [7:0] b = 8'($urandom);
    return b == 8'hEB ? 8'h55 : b;
  endfunction
  task automatic send(input logic [7:0] s, d, o, c, t6, t7, input int pre);
    exp_q.push_back(model(s, d, o, c, t6, t7));
    if (pre == 1) repeat ($urandom_range(1, 3)) fifo.push_back(junk());
    if (pre == 2) begin fifo.push_back(8'h55); fifo.push_back(8'hEB); end
    fifo.push_back(8'hEB); fifo.push_back(8'h90); fifo.push_back(s); fifo.push_back(d);
    fifo.push_back(o); fifo.push_back(c); fifo.push_back(t6); fifo.push_back(t7);
  endtask
  task automatic frame(input logic [7:0] o, input int corrupt, input int pre);
    logic [7:0] s = 8'($urandom);
    logic [7:0] d = DEST, t6 = 8'h09, t7 = 8'hD7;
    logic [7:0] c = 8'(8'h00 - s - DEST - o);
    if (corrupt == 1) c = c ^ 8'h01;
    if (corrupt == 2) d = d ^ 8'h01;
    if (corrupt == 3) t6 = t6 ^ 8'h10;
    if (corrupt == 4) t7 = t7 ^ 8'h01;
    send(s, d, o, c, t6, t7, pre);
  endtask
  task automatic stall(input int n);
    logic [7:0] b[8];
    ev_t e = '0;
    b[0] = 8'hEB; b[1] = 8'h90; b[3] = DEST;
    for (int i = 2; i < 8; i++) if (i != 3) b[i] = 8'($urandom);
    e.err = 1'b1; e.sel = m_sel; e.pon = m_pon;
    exp_q.push_back(e);
    for (int i = 0; i < n; i++) fifo.push_back(b[i]);
  endtask
  task automatic hunt_err();
    logic [7:0] x = 8'($urandom);
    ev_t e = '0;
    if (x == 8'h90 || x == 8'hEB) x = 8'h12;
    e.err = 1'b1; e.sel = m_sel; e.pon = m_pon;
    exp_q.push_back(e);
    fifo.push_back(8'hEB);
    fifo.push_back(x);
  endtask
  task automatic drain();
    int n = 0;
    while ((fifo.size() != 0 || exp_q.size() != 0) && n < 400) begin tick(); n++; end
    chk("drain_bound", n < 400, 1);
    repeat (3) tick();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] op;
    int r;
    rf_counter = 1; rdr = 8'hEB;
    repeat (3) @(negedge clk);
    chk("reset", {rf_pop, tf_push, tdr, com_sel, force_swi, rst_out, power_on, frame_ok, error},
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0});
    rf_counter = 0; rdr = 8'h00;
    rst_n = 1'b1;
    repeat (2) tick();
    active_ch = 1'b0;
    send(8'h01, DEST, 8'h01, 8'h53, 8'h09, 8'hD7, 0); drain();
    send(8'h01, DEST, 8'h0B, 8'h49, 8'h09, 8'hD7, 0); drain();
    send(8'h01, DEST, 8'h00, 8'h53, 8'h09, 8'hD7, 0); drain();
    send(8'h01, DEST, 8'h11, 8'h43, 8'h09, 8'hD7, 0); drain();
    send(8'h01, DEST, 8'h10, 8'h44, 8'h09, 8'hD7, 0); drain();
    repeat (20) tick();
    send(8'h01, DEST, 8'h21, 8'h33, 8'h09, 8'hD7, 2); drain();
    send(8'h01, DEST, 8'h31, 8'h23, 8'h09, 8'hD7, 0); drain();
    stall(5); drain();
    frame(8'h21, 0, 0); drain();
    hunt_err(); drain();
    frame(8'h01, 0, 0); frame(8'hF0, 0, 0); drain();
    for (int it = 0; it < 60; it++) begin
      active_ch = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 9);
      if (r == 8) stall($urandom_range(1, 7));
      else if (r == 9) hunt_err();
      else begin
        repeat ($urandom_range(1, 2)) begin
          r = $urandom_range(0, 5);
          op = r < 4 ? {4'(r), 4'($urandom_range(0, 3))} : r == 4 ? 8'hF0 : 8'($urandom);
          r = $urandom_range(0, 9);
          frame(op, r < 5 ? r : 0, $urandom_range(0, 2));
        end
      end
      drain();
    end
    active_ch = 1'b0;
    frame(8'h31, 0, 0); frame(8'h01, 0, 0); drain();
    frame(8'h11, 0, 0); drain();
    fifo.push_back(8'hEB); fifo.push_back(8'h90); fifo.push_back(8'h01);
    repeat (4) tick();
    chk("pre_reset_rst", rst_out[1], 1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {rf_pop, tf_push, tdr, com_sel, force_swi, rst_out, power_on, frame_ok, error},
        {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 1'b0});
    fifo.delete();
    pops_done = pops_seen;
    m_sel = 1'b0; m_pon = '1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    frame(8'h01, 0, 0); drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
